alu_seq: RTL

- Parametrised, handshaked successor to the combinational integer ALU in the execute stage.
- Adds XLEN-generic width, a registered result with valid/ready flow control, and a multi-cycle radix-2 divider for DIV/DIVU/REM/REMU.
- Sits between operand fetch and writeback. Stalls the issuing pipeline through in_ready while a division iterates.

---
 rtl/alu_seq_if.sv | 36 +++
 rtl/alu_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Handshake and operand/result bundle for alu_seq.
//                Request side: in_valid/in_ready, rega, regb, alu_opcode.
//                Response side: out_valid/out_ready, alu_res, flag_zero,
//                flag_of, plus the busy status of the divider.
//                master = operand issuer / result consumer, slave = the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rega;
  logic [XLEN-1:0] regb;
  logic [4:0]      alu_opcode;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_res;
  logic            flag_zero;
  logic            flag_of;
  logic            busy;

  modport master (
    output in_valid, rega, regb, alu_opcode, out_ready,
    input  in_ready, out_valid, alu_res, flag_zero, flag_of, busy
  );

  modport slave (
    input  in_valid, rega, regb, alu_opcode, out_ready,
    output in_ready, out_valid, alu_res, flag_zero, flag_of, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered, valid/ready handshaked integer ALU with a
//                radix-2 restoring divider for DIV/DIVU/REM/REMU.
//                Single-cycle ops have latency 1; divisions take XLEN+2
//                cycles (IDLE -> DIV -> DONE -> IDLE) and hold in_ready low.
//  Ports       : clk, rst (sync, active-high)
//                bus (alu_seq_if.slave): in_valid/in_ready, rega, regb,
//                alu_opcode, out_valid/out_ready, alu_res, flag_zero,
//                flag_of, busy
//  Options     : ALU_DIV_EARLY_EN - when defined, divisions with a zero
//                divisor or |dividend| < |divisor| bypass the DIV state
//                (latency 2, identical results).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input wire     clk,
  input wire     rst,
  alu_seq_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [4:0] C_OP_ADD  = 5'b00000;
  localparam logic [4:0] C_OP_SUB  = 5'b00001;
  localparam logic [4:0] C_OP_LOR  = 5'b00010;
  localparam logic [4:0] C_OP_LAND = 5'b00011;
  localparam logic [4:0] C_OP_LXOR = 5'b00100;
  localparam logic [4:0] C_OP_LSL  = 5'b00101;
  localparam logic [4:0] C_OP_LSR  = 5'b00110;
  localparam logic [4:0] C_OP_ASR  = 5'b00111;
  localparam logic [4:0] C_OP_SLT  = 5'b01000;
  localparam logic [4:0] C_OP_DIV  = 5'b01101;
  localparam logic [4:0] C_OP_DIVU = 5'b01110;
  localparam logic [4:0] C_OP_REM  = 5'b01111;
  localparam logic [4:0] C_OP_REMU = 5'b10000;
  localparam logic [4:0] C_OP_SLTU = 5'b10001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Registered state
  state_t            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [XLEN-1:0]   quo_q,       quo_d;     // dividend shifts out, quotient shifts in
  logic [XLEN-1:0]   rem_q,       rem_d;
  logic [XLEN-1:0]   dvs_q,       dvs_d;     // divisor magnitude
  logic              qneg_q,      qneg_d;
  logic              rneg_q,      rneg_d;
  logic              isrem_q,     isrem_d;
  logic              div0_q,      div0_d;
  logic              ovf_q,       ovf_d;
  logic              busy_q,      busy_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   res_q,       res_d;
  logic              zero_q,      zero_d;
  logic              of_q,        of_d;

  // Combinational helpers
  logic [XLEN-1:0]   w_a, w_b;
  logic [4:0]        w_op;
  logic              w_in_ready, w_accept;
  logic              w_is_div, w_signed_div;
  logic              w_sign_a, w_sign_b;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic              w_ovf, w_early;
  logic [XLEN:0]     w_sum;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]   w_alu_res;
  logic              w_alu_of;
  logic [XLEN:0]     w_rem_sh, w_rem_sub;
  logic              w_ge;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_div_res;

  assign w_a  = bus.rega;
  assign w_b  = bus.regb;
  assign w_op = bus.alu_opcode;

  assign w_in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  assign w_is_div     = (w_op == C_OP_DIV) || (w_op == C_OP_DIVU) ||
                        (w_op == C_OP_REM) || (w_op == C_OP_REMU);
  assign w_signed_div = (w_op == C_OP_DIV) || (w_op == C_OP_REM);
  assign w_sign_a     = w_signed_div && w_a[XLEN-1];
  assign w_sign_b     = w_signed_div && w_b[XLEN-1];
  assign w_mag_a      = w_sign_a ? (-w_a) : w_a;
  assign w_mag_b      = w_sign_b ? (-w_b) : w_b;
  // Most-negative / -1 : magnitude divide already yields the wrapped
  // quotient and zero remainder; only the flag needs special handling.
  assign w_ovf        = w_signed_div && (w_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (w_b == {XLEN{1'b1}});

`ifdef ALU_DIV_EARLY_EN
  assign w_early = (w_b == '0) || (w_mag_a < w_mag_b);
`else
  assign w_early = 1'b0;
`endif

  // Single-cycle operations
  assign w_sum   = {1'b0, w_a} + {1'b0, w_b};
  assign w_shamt = w_b[SHAMT_W-1:0];

  always_comb begin
    w_alu_res = '0;
    w_alu_of  = 1'b0;
    case (w_op)
      C_OP_ADD: begin
        w_alu_res = w_sum[XLEN-1:0];
        w_alu_of  = w_sum[XLEN];
      end
      C_OP_SUB:  w_alu_res = w_a - w_b;
      C_OP_LOR:  w_alu_res = w_a | w_b;
      C_OP_LAND: w_alu_res = w_a & w_b;
      C_OP_LXOR: w_alu_res = w_a ^ w_b;
      C_OP_LSL:  w_alu_res = w_a << w_shamt;
      C_OP_LSR:  w_alu_res = w_a >> w_shamt;
      C_OP_ASR:  w_alu_res = $signed(w_a) >>> w_shamt;
      C_OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      C_OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      default: begin
        w_alu_res = '0;
        w_alu_of  = 1'b0;
      end
    endcase
  end

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign w_rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, dvs_q};
  assign w_ge      = (w_rem_sh >= {1'b0, dvs_q});

  // Sign fix-up. A zero divisor must return all ones regardless of the
  // operand signs, so the quotient negation is bypassed in that case.
  assign w_quo_fix = div0_q ? {XLEN{1'b1}} : (qneg_q ? (-quo_q) : quo_q);
  assign w_rem_fix = rneg_q ? (-rem_q) : rem_q;
  assign w_div_res = isrem_q ? w_rem_fix : w_quo_fix;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    isrem_d     = isrem_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    res_d       = res_q;
    zero_d      = zero_q;
    of_d        = of_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_div) begin
            dvs_d   = w_mag_b;
            qneg_d  = w_sign_a ^ w_sign_b;
            rneg_d  = w_sign_a;
            isrem_d = (w_op == C_OP_REM) || (w_op == C_OP_REMU);
            div0_d  = (w_b == '0);
            ovf_d   = w_ovf;
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(XLEN);
            if (w_early) begin
              // Trivial cases: quotient is 0 (or all ones for /0), remainder is |A|.
              quo_d   = (w_b == '0) ? {XLEN{1'b1}} : '0;
              rem_d   = w_mag_a;
              state_d = S_DONE;
            end else begin
              quo_d   = w_mag_a;
              rem_d   = '0;
              state_d = S_DIV;
            end
          end else begin
            out_valid_d = 1'b1;
            res_d       = w_alu_res;
            zero_d      = (w_alu_res == '0);
            of_d        = w_alu_of;
          end
        end
      end
      S_DIV: begin
        quo_d = {quo_q[XLEN-2:0], w_ge};
        rem_d = w_ge ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid_d = 1'b1;
        res_d       = w_div_res;
        zero_d      = (w_div_res == '0);
        of_d        = ovf_q;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      isrem_q     <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      isrem_q     <= isrem_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      of_q        <= of_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_res   = res_q;
  assign bus.flag_zero = zero_q;
  assign bus.flag_of   = of_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire
